// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants: ALU source codes, ALU op width, bubble controls
package cpu_pkg;

   localparam int ALU_OP_W = 4;

   // ALU operand select codes, shared with the ALU_Src2 mux in EX
   localparam logic [7:0] SRC_RY     = 8'h06;
   localparam logic [7:0] SRC_ZERO   = 8'h10;
   localparam logic [7:0] SRC_S_IMM4 = 8'h14;
   localparam logic [7:0] SRC_S_IMM5 = 8'h15;
   localparam logic [7:0] SRC_S_IMM8 = 8'h16;
   localparam logic [7:0] SRC_ONE    = 8'h26;

   localparam logic [ALU_OP_W-1:0] BUBBLE_ALU_OP = '0;
   localparam logic [3:0]          BUBBLE_RD     = 4'h0;
   localparam logic [7:0]          BUBBLE_SRC    = SRC_ZERO;

   typedef enum logic [1:0] {
      LD_LOAD   = 2'd0,
      LD_HOLD   = 2'd1,
      LD_BUBBLE = 2'd2
   } load_mode_e;

   // flush outranks stall so a stalled slot can still be squashed
   function automatic load_mode_e select_mode(input logic flush, input logic stall);
      if (flush)
         return LD_BUBBLE;
      else if (stall)
         return LD_HOLD;
      else
         return LD_LOAD;
   endfunction

endpackage

// File: rtl/imm_ext.sv
// rtl/imm_ext.sv - ID-stage immediate extraction and extension (imm4/imm5/imm8)
module imm_ext #(
   parameter int W = 16
) (
   input  logic [15:0]  instr_id,
   input  logic         imm8_zext_id,
   output logic [W-1:0] imm4,
   output logic [W-1:0] imm5,
   output logic [W-1:0] imm8
);

   logic unused_instr_hi;

   assign unused_instr_hi = ^instr_id[15:8];

   assign imm4 = {{(W-4){instr_id[3]}}, instr_id[3:0]};
   assign imm5 = {{(W-5){instr_id[4]}}, instr_id[4:0]};
   assign imm8 = {{(W-8){instr_id[7] & ~imm8_zext_id}}, instr_id[7:0]};

endmodule

// File: rtl/id_ex_reg.sv
// rtl/id_ex_reg.sv - ID/EX pipeline register with stall hold, flush bubble and bubble counter
module id_ex_reg
   import cpu_pkg::*;
#(
   parameter int W     = 16,
   parameter int CNT_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall,
   input  logic                flush,
   input  logic [15:0]         instr_id,
   input  logic                imm8_zext_id,
   input  logic [W-1:0]        pc_id,
   input  logic [W-1:0]        data_rx_id,
   input  logic [W-1:0]        data_ry_id,
   input  logic [7:0]          alu_src1_id,
   input  logic [7:0]          alu_src2_id,
   input  logic [ALU_OP_W-1:0] alu_op_id,
   input  logic [3:0]          rd_id,
   input  logic                reg_write_id,
   input  logic                mem_read_id,
   input  logic                mem_write_id,
   input  logic                valid_id,
   output logic [W-1:0]        pc_ex,
   output logic [W-1:0]        data_rx_ex,
   output logic [W-1:0]        data_ry_ex,
   output logic [7:0]          alu_src1_ex,
   output logic [7:0]          alu_src2_ex,
   output logic [ALU_OP_W-1:0] alu_op_ex,
   output logic [3:0]          rd_ex,
   output logic                reg_write_ex,
   output logic                mem_read_ex,
   output logic                mem_write_ex,
   output logic                valid_ex,
   output logic [W-1:0]        imm4_ex,
   output logic [W-1:0]        imm5_ex,
   output logic [W-1:0]        imm8_ex,
   output logic [CNT_W-1:0]    bubble_cnt
);

   logic [W-1:0] imm4_id;
   logic [W-1:0] imm5_id;
   logic [W-1:0] imm8_id;
   load_mode_e   mode;

   imm_ext #(.W(W)) u_imm_ext (
      .instr_id     (instr_id),
      .imm8_zext_id (imm8_zext_id),
      .imm4         (imm4_id),
      .imm5         (imm5_id),
      .imm8         (imm8_id)
   );

   always_comb begin
      mode = select_mode(flush, stall);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_ex        <= '0;
         data_rx_ex   <= '0;
         data_ry_ex   <= '0;
         alu_src1_ex  <= BUBBLE_SRC;
         alu_src2_ex  <= BUBBLE_SRC;
         alu_op_ex    <= BUBBLE_ALU_OP;
         rd_ex        <= BUBBLE_RD;
         reg_write_ex <= 1'b0;
         mem_read_ex  <= 1'b0;
         mem_write_ex <= 1'b0;
         valid_ex     <= 1'b0;
         imm4_ex      <= '0;
         imm5_ex      <= '0;
         imm8_ex      <= '0;
      end else begin
         case (mode)
            LD_BUBBLE: begin
               pc_ex        <= '0;
               data_rx_ex   <= '0;
               data_ry_ex   <= '0;
               alu_src1_ex  <= BUBBLE_SRC;
               alu_src2_ex  <= BUBBLE_SRC;
               alu_op_ex    <= BUBBLE_ALU_OP;
               rd_ex        <= BUBBLE_RD;
               reg_write_ex <= 1'b0;
               mem_read_ex  <= 1'b0;
               mem_write_ex <= 1'b0;
               valid_ex     <= 1'b0;
               imm4_ex      <= '0;
               imm5_ex      <= '0;
               imm8_ex      <= '0;
            end
            LD_LOAD: begin
               pc_ex        <= pc_id;
               data_rx_ex   <= data_rx_id;
               data_ry_ex   <= data_ry_id;
               alu_src1_ex  <= alu_src1_id;
               alu_src2_ex  <= alu_src2_id;
               alu_op_ex    <= alu_op_id;
               rd_ex        <= rd_id;
               reg_write_ex <= reg_write_id;
               mem_read_ex  <= mem_read_id;
               mem_write_ex <= mem_write_id;
               valid_ex     <= valid_id;
               imm4_ex      <= imm4_id;
               imm5_ex      <= imm5_id;
               imm8_ex      <= imm8_id;
            end
            default: ;
         endcase
      end
   end

   // Counts flush edges only; a pass-through of valid_id = 0 is not a bubble
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         bubble_cnt <= '0;
      else if (flush && (bubble_cnt != {CNT_W{1'b1}}))
         bubble_cnt <= bubble_cnt + 1'b1;
   end

endmodule

// File: tb/tb_id_ex_reg.sv
// tb/tb_id_ex_reg.sv - randomized self-checking bench for id_ex_reg against a behavioural model
module tb_id_ex_reg;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        flush;
   logic [15:0] instr_id;
   logic        imm8_zext_id;
   logic [15:0] pc_id;
   logic [15:0] data_rx_id;
   logic [15:0] data_ry_id;
   logic [7:0]  alu_src1_id;
   logic [7:0]  alu_src2_id;
   logic [3:0]  alu_op_id;
   logic [3:0]  rd_id;
   logic        reg_write_id;
   logic        mem_read_id;
   logic        mem_write_id;
   logic        valid_id;

   logic [15:0] pc_ex, data_rx_ex, data_ry_ex, imm4_ex, imm5_ex, imm8_ex, bubble_cnt;
   logic [7:0]  alu_src1_ex, alu_src2_ex;
   logic [3:0]  alu_op_ex, rd_ex;
   logic        reg_write_ex, mem_read_ex, mem_write_ex, valid_ex;

   logic [15:0] s_pc_ex, s_data_rx_ex, s_data_ry_ex, s_imm4_ex, s_imm5_ex, s_imm8_ex;
   logic [7:0]  s_alu_src1_ex, s_alu_src2_ex;
   logic [3:0]  s_alu_op_ex, s_rd_ex, s_bubble_cnt;
   logic        s_reg_write_ex, s_mem_read_ex, s_mem_write_ex, s_valid_ex;

   int checks = 0;
   int errors = 0;

   // Reference state: one record of what EX should hold
   typedef struct {
      int pc, rx, ry, src1, src2, op, rd, rw, mr, mw, v, i4, i5, i8;
   } ex_t;
   ex_t exp_ex;
   int  exp_cnt16;
   int  exp_cnt4;

   id_ex_reg dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .instr_id(instr_id), .imm8_zext_id(imm8_zext_id), .pc_id(pc_id),
      .data_rx_id(data_rx_id), .data_ry_id(data_ry_id),
      .alu_src1_id(alu_src1_id), .alu_src2_id(alu_src2_id), .alu_op_id(alu_op_id),
      .rd_id(rd_id), .reg_write_id(reg_write_id), .mem_read_id(mem_read_id),
      .mem_write_id(mem_write_id), .valid_id(valid_id),
      .pc_ex(pc_ex), .data_rx_ex(data_rx_ex), .data_ry_ex(data_ry_ex),
      .alu_src1_ex(alu_src1_ex), .alu_src2_ex(alu_src2_ex), .alu_op_ex(alu_op_ex),
      .rd_ex(rd_ex), .reg_write_ex(reg_write_ex), .mem_read_ex(mem_read_ex),
      .mem_write_ex(mem_write_ex), .valid_ex(valid_ex),
      .imm4_ex(imm4_ex), .imm5_ex(imm5_ex), .imm8_ex(imm8_ex), .bubble_cnt(bubble_cnt)
   );

   id_ex_reg #(.W(16), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .instr_id(instr_id), .imm8_zext_id(imm8_zext_id), .pc_id(pc_id),
      .data_rx_id(data_rx_id), .data_ry_id(data_ry_id),
      .alu_src1_id(alu_src1_id), .alu_src2_id(alu_src2_id), .alu_op_id(alu_op_id),
      .rd_id(rd_id), .reg_write_id(reg_write_id), .mem_read_id(mem_read_id),
      .mem_write_id(mem_write_id), .valid_id(valid_id),
      .pc_ex(s_pc_ex), .data_rx_ex(s_data_rx_ex), .data_ry_ex(s_data_ry_ex),
      .alu_src1_ex(s_alu_src1_ex), .alu_src2_ex(s_alu_src2_ex), .alu_op_ex(s_alu_op_ex),
      .rd_ex(s_rd_ex), .reg_write_ex(s_reg_write_ex), .mem_read_ex(s_mem_read_ex),
      .mem_write_ex(s_mem_write_ex), .valid_ex(s_valid_ex),
      .imm4_ex(s_imm4_ex), .imm5_ex(s_imm5_ex), .imm8_ex(s_imm8_ex), .bubble_cnt(s_bubble_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int sext(input int v, input int bits);
      if (v >= (1 << (bits - 1)))
         return (v - (1 << bits)) & 16'hFFFF;
      return v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      exp_ex = '{pc:0, rx:0, ry:0, src1:'h10, src2:'h10, op:0, rd:0,
                 rw:0, mr:0, mw:0, v:0, i4:0, i5:0, i8:0};
      exp_cnt16 = 0;
      exp_cnt4  = 0;
   endtask

   task automatic model_edge();
      int lo;
      if (flush) begin
         exp_ex = '{pc:0, rx:0, ry:0, src1:'h10, src2:'h10, op:0, rd:0,
                    rw:0, mr:0, mw:0, v:0, i4:0, i5:0, i8:0};
         if (exp_cnt16 < 65535) exp_cnt16++;
         if (exp_cnt4 < 15) exp_cnt4++;
      end else if (!stall) begin
         lo = int'(instr_id[7:0]);
         exp_ex.pc   = int'(pc_id);
         exp_ex.rx   = int'(data_rx_id);
         exp_ex.ry   = int'(data_ry_id);
         exp_ex.src1 = int'(alu_src1_id);
         exp_ex.src2 = int'(alu_src2_id);
         exp_ex.op   = int'(alu_op_id);
         exp_ex.rd   = int'(rd_id);
         exp_ex.rw   = int'(reg_write_id);
         exp_ex.mr   = int'(mem_read_id);
         exp_ex.mw   = int'(mem_write_id);
         exp_ex.v    = int'(valid_id);
         exp_ex.i4   = sext(lo % 16, 4);
         exp_ex.i5   = sext(lo % 32, 5);
         exp_ex.i8   = imm8_zext_id ? lo : sext(lo, 8);
      end
   endtask

   task automatic check_all(input string step);
      chk({step, ".pc"},       32'(pc_ex),        32'(exp_ex.pc));
      chk({step, ".rx"},       32'(data_rx_ex),   32'(exp_ex.rx));
      chk({step, ".ry"},       32'(data_ry_ex),   32'(exp_ex.ry));
      chk({step, ".src1"},     32'(alu_src1_ex),  32'(exp_ex.src1));
      chk({step, ".src2"},     32'(alu_src2_ex),  32'(exp_ex.src2));
      chk({step, ".op"},       32'(alu_op_ex),    32'(exp_ex.op));
      chk({step, ".rd"},       32'(rd_ex),        32'(exp_ex.rd));
      chk({step, ".rw"},       32'(reg_write_ex), 32'(exp_ex.rw));
      chk({step, ".mr"},       32'(mem_read_ex),  32'(exp_ex.mr));
      chk({step, ".mw"},       32'(mem_write_ex), 32'(exp_ex.mw));
      chk({step, ".valid"},    32'(valid_ex),     32'(exp_ex.v));
      chk({step, ".imm4"},     32'(imm4_ex),      32'(exp_ex.i4));
      chk({step, ".imm5"},     32'(imm5_ex),      32'(exp_ex.i5));
      chk({step, ".imm8"},     32'(imm8_ex),      32'(exp_ex.i8));
      chk({step, ".cnt16"},    32'(bubble_cnt),   32'(exp_cnt16));
      chk({step, ".cnt4"},     32'(s_bubble_cnt), 32'(exp_cnt4));
      chk({step, ".w4.imm8"},  32'(s_imm8_ex),    32'(exp_ex.i8));
   endtask

   task automatic rand_inputs();
      instr_id     = 16'($urandom);
      imm8_zext_id = 1'($urandom);
      pc_id        = 16'($urandom);
      data_rx_id   = 16'($urandom);
      data_ry_id   = 16'($urandom);
      alu_src1_id  = 8'($urandom);
      alu_src2_id  = 8'($urandom);
      alu_op_id    = 4'($urandom);
      rd_id        = 4'($urandom);
      reg_write_id = 1'($urandom);
      mem_read_id  = 1'($urandom);
      mem_write_id = 1'($urandom);
      valid_id     = 1'($urandom);
   endtask

   task automatic tick(input string step);
      @(posedge clk);
      model_edge();
      #1;
      check_all(step);
   endtask

   initial begin
      rst = 1'b1;
      stall = 1'b0;
      flush = 1'b0;
      rand_inputs();
      model_reset();
      #2;
      check_all("reset");
      @(negedge clk);
      rst = 1'b0;

      // Directed normal load
      instr_id = 16'h4F0C; alu_src2_id = 8'h14; imm8_zext_id = 1'b0;
      tick("load4F0C");
      chk("load4F0C.imm4_const", 32'(imm4_ex), 32'h0000FFFC);

      // imm8 sign vs zero extension of 0x80
      instr_id = 16'h1280; imm8_zext_id = 1'b0;
      tick("imm80_sext");
      chk("imm80_sext.const", 32'(imm8_ex), 32'h0000FF80);
      imm8_zext_id = 1'b1;
      tick("imm80_zext");
      chk("imm80_zext.const", 32'(imm8_ex), 32'h00000080);

      // Randomized stall/flush mix
      for (int i = 0; i < 60; i++) begin
         rand_inputs();
         stall = ($urandom_range(0, 3) == 0);
         flush = ($urandom_range(0, 5) == 0);
         tick("rand");
      end

      // Stall held three cycles while ID inputs change
      flush = 1'b0;
      stall = 1'b0;
      rand_inputs();
      tick("pre_stall");
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rand_inputs();
         tick("stall");
      end
      stall = 1'b0;
      rand_inputs();
      tick("post_stall");

      // Flush together with stall
      rand_inputs();
      reg_write_id = 1'b1;
      valid_id = 1'b1;
      stall = 1'b1;
      flush = 1'b1;
      tick("flush_stall");
      chk("flush_stall.rw_const", 32'(reg_write_ex), 32'h0);
      chk("flush_stall.src2_const", 32'(alu_src2_ex), 32'h10);
      stall = 1'b0;
      flush = 1'b0;

      // Mid-cycle asynchronous reset with loaded contents
      rand_inputs();
      alu_src2_id = 8'h26;
      valid_id = 1'b1;
      tick("pre_reset");
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_all("async_reset");
      #2;
      rst = 1'b0;

      // Saturation of the 4-bit counter
      flush = 1'b1;
      for (int i = 0; i < 20; i++) begin
         rand_inputs();
         tick("sat");
      end
      chk("sat.cnt4_const", 32'(s_bubble_cnt), 32'hF);
      chk("sat.cnt16_const", 32'(bubble_cnt), 32'd20);
      flush = 1'b0;
      rand_inputs();
      valid_id = 1'b0;
      tick("invalid_passthru");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
